// File: rtl/rl_noc_pkg.sv
// Shared NoC definitions for the routing-logic arbiter slice.
//   FLIT_W     : flit width (type bit, 3-bit destination, 7-bit payload)
//   flit_t     : flit type
//   TYPE_BIT / DEST_LSB / DEST_MSB / PAYLOAD_LSB : flit field positions
//   NUM_PORTS  : number of arbitrated inputs
//   rr_wrap_inc: modulo-3 increment used by the round-robin search
package rl_noc_pkg;

    localparam int unsigned FLIT_W      = 11;
    typedef logic [FLIT_W-1:0] flit_t;

    localparam int unsigned TYPE_BIT    = 0;
    localparam int unsigned DEST_LSB    = 1;
    localparam int unsigned DEST_MSB    = 3;
    localparam int unsigned PAYLOAD_LSB = 4;

    localparam int unsigned NUM_PORTS   = 3;

    typedef logic [1:0] rr_idx_t;

    // Next index in the 0 -> 1 -> 2 -> 0 search ring.
    function automatic rr_idx_t rr_wrap_inc(input rr_idx_t idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rl_arbiter_if.sv
// Handshake bundle between the neighbouring stages / downstream consumer and rl_arbiter.
//   in_valid  : per-input flit valid
//   in_data   : per-input flit, input i at [i*WIDTH +: WIDTH]
//   in_ready  : one-hot grant back to the inputs
//   out_valid : output FIFO head valid
//   out_data  : output FIFO head flit
//   out_ready : downstream accept
// Modports: master = environment side (senders + consumer), slave = arbiter side.
interface rl_arbiter_if #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned NUM_IN = 3
);
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic                    out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rl_arb_fifo.sv
// Small circular output FIFO for rl_arbiter.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage and pointers)
//   push       : write push_data at the tail (ignored when full)
//   push_data  : flit to write
//   pop        : advance the head (ignored when empty)
//   pop_data   : head flit; while empty, the most recently popped flit
//   count      : occupancy
//   full/empty : occupancy flags
module rl_arb_fifo #(
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned OUT_DEPTH = 2,
    localparam int unsigned PtrW     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1,
    localparam int unsigned CntW     = $clog2(OUT_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [OUT_DEPTH];
    logic [PtrW-1:0]  head_q, tail_q, head_prev;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CntW'(OUT_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Slot behind the head holds the last popped flit; showing it while empty keeps
    // out_data stable once the FIFO drains. Pushes never target it while empty.
    assign head_prev = (head_q == '0) ? PtrW'(OUT_DEPTH - 1) : head_q - 1'b1;
    assign pop_data  = empty ? mem_q[head_prev] : mem_q[head_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[tail_q] <= push_data;
                tail_q        <= ptr_inc(tail_q);
            end
            if (do_pop) begin
                head_q <= ptr_inc(head_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rl_arbiter.sv
// Three-input round-robin arbiter feeding the routing-logic arbiter input through a small
// output FIFO. Grants depend only on input valids, the round-robin pointer and FIFO
// occupancy, so out_ready never reaches in_ready combinationally.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rl_arbiter_if.slave (in_valid/in_data/in_ready, out_valid/out_data/out_ready)
//   grant_cnt  : per-input saturating accepted-flit counters, input i at [i*CNT_W +: CNT_W]
//                (only when RL_ARB_STATS_EN is defined)
// Optional feature macro: RL_ARB_STATS_EN
module rl_arbiter
    import rl_noc_pkg::*;
#(
    parameter int unsigned WIDTH     = FLIT_W,
    parameter int unsigned NUM_IN    = NUM_PORTS,
    parameter int unsigned OUT_DEPTH = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rl_arbiter_if.slave        bus
`ifdef RL_ARB_STATS_EN
    ,
    output logic [NUM_IN*CNT_W-1:0] grant_cnt
`endif
);

    localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);

    if (NUM_IN != 3) begin : g_bad_num_in
        $error("rl_arbiter: only NUM_IN == 3 is supported");
    end
    if (OUT_DEPTH < 1) begin : g_bad_depth
        $error("rl_arbiter: OUT_DEPTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("rl_arbiter: CNT_W must be at least 1");
    end

    rr_idx_t           rr_ptr_q, grant_idx, cand;
    logic              grant_vld;
    logic [NUM_IN-1:0] grant;
    logic [WIDTH-1:0]  push_data;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [CntW-1:0]   fifo_count;

    // Search rr_ptr+1, +2, +3 (mod 3); no grant while full or in reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = rr_wrap_inc(cand);
            if (!grant_vld && bus.in_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (!rst_n || fifo_full) begin
            grant_vld = 1'b0;
        end
        grant = '0;
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                push_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd2;
        end else if (grant_vld) begin
            rr_ptr_q <= grant_idx;
        end
    end

    assign fifo_pop      = bus.out_valid && bus.out_ready;
    assign bus.out_valid = !fifo_empty;

    rl_arb_fifo #(
        .WIDTH     (WIDTH),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant_vld),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (bus.out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_count_in_range : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CntW'(OUT_DEPTH));

`ifdef RL_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_IN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (grant[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cnt_out
        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_rl_arbiter.sv
// Randomised + directed bench for rl_arbiter against a queue-based reference model.
module tb_rl_arbiter;
    import rl_noc_pkg::*;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int          SRC_SZ = 256;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rl_arbiter_if #(.WIDTH(FLIT_W), .NUM_IN(3)) bus ();

`ifdef RL_ARB_STATS_EN
    logic [3*CNT_W-1:0] grant_cnt;
`endif

    rl_arbiter #(
        .WIDTH     (FLIT_W),
        .NUM_IN    (3),
        .OUT_DEPTH (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef RL_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .bus       (bus)
    );

    // Per-input sender queues: a flit stays offered until the model says it transferred.
    flit_t src_mem [3][SRC_SZ];
    int    src_rd [3];
    int    src_wr [3];

    // Reference model state.
    flit_t exp_q[$];
    int    rr_last;
    flit_t last_out;
    int    exp_cnt [3];
    logic  ordy;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic add_flit(input int i, input flit_t f);
        src_mem[i][src_wr[i] % SRC_SZ] = f;
        src_wr[i]++;
    endtask

    function automatic flit_t rand_flit();
        flit_t f;
        f = '0;
        f[TYPE_BIT]                 = 1'($urandom);
        f[DEST_MSB:DEST_LSB]        = 3'($urandom);
        f[FLIT_W-1:PAYLOAD_LSB]     = 7'($urandom);
        return f;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        rr_last  = 2;
        last_out = '0;
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    endtask

    // One clock: drive at negedge, check after settling, advance the model at posedge.
    task automatic cycle();
        logic [2:0] exp_rdy;
        int         gi;
        bit         pop;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid[i] = (src_wr[i] != src_rd[i]);
            bus.in_data[i*FLIT_W +: FLIT_W] = bus.in_valid[i] ?
                src_mem[i][src_rd[i] % SRC_SZ] : flit_t'($urandom);
        end
        bus.out_ready = ordy;
        #1;
        gi = -1;
        if (exp_q.size() < DEPTH) begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (rr_last + k) % 3;
                if (gi < 0 && src_wr[idx] != src_rd[idx]) gi = idx;
            end
        end
        exp_rdy = '0;
        if (gi >= 0) exp_rdy[gi] = 1'b1;
        check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check_eq("out_valid", 32'(bus.out_valid), (exp_q.size() > 0) ? 32'd1 : 32'd0);
        check_eq("out_data", 32'(bus.out_data), 32'((exp_q.size() > 0) ? exp_q[0] : last_out));
`ifdef RL_ARB_STATS_EN
        for (int i = 0; i < 3; i++) begin
            check_eq("grant_cnt", 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'(exp_cnt[i]));
        end
`endif
        pop = ordy && (exp_q.size() > 0);
        @(posedge clk);
        if (pop) last_out = exp_q.pop_front();
        if (gi >= 0) begin
            exp_q.push_back(src_mem[gi][src_rd[gi] % SRC_SZ]);
            src_rd[gi]++;
            rr_last = gi;
            if (exp_cnt[gi] < CNT_MAX) exp_cnt[gi]++;
        end
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear immediately.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        model_reset();
        ordy          = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Power-on reset.
        #12;
        check_eq("por_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("por_out_data", 32'(bus.out_data), 32'd0);
        check_eq("por_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single input stream, one-cycle latency.
        ordy = 1'b1;
        add_flit(0, 11'h011);
        add_flit(0, 11'h013);
        add_flit(0, 11'h015);
        run(6);

        // Full contention, rr_ptr wrap.
        for (int k = 0; k < 4; k++) begin
            add_flit(0, 11'h100);
            add_flit(1, 11'h200);
            add_flit(2, 11'h300);
        end
        run(16);

        // Backpressure with depth-2 FIFO: fill, single pop, resume.
        ordy = 1'b0;
        for (int k = 0; k < 4; k++) add_flit(2, flit_t'(11'h3A0 + k));
        run(4);
        ordy = 1'b1;
        run(1);
        ordy = 1'b0;
        run(2);
        ordy = 1'b1;
        run(6);

        // Reset mid-stream with two flits buffered; inputs still valid during reset.
        ordy = 1'b0;
        add_flit(0, 11'h0A1);
        add_flit(0, 11'h0A3);
        add_flit(0, 11'h0A5);
        run(3);
        src_rd[0] = src_wr[0];
        async_reset();
        ordy = 1'b1;
        add_flit(1, 11'h2A3);
        run(3);

        // Stats: 20 transfers from input 0 from a clean reset.
        async_reset();
        for (int k = 0; k < 20; k++) add_flit(0, flit_t'(11'h040 + k));
        run(24);

        // Random traffic and backpressure.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ((src_wr[i] - src_rd[i]) < 3 && $urandom_range(0, 2) == 0) begin
                    add_flit(i, rand_flit());
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        ordy = 1'b1;
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rl_arbiter.md
# rl_arbiter

Clocked three-input round-robin arbiter that merges flits from the neighbouring routing stages into the single stream consumed by a router's routing-logic arbiter input. It sits directly upstream of `RL_bottom.arbiter_input`. Each input carries 11-bit flits: bit 0 is type, [3:1] is the destination router and [10:4] is payload. The block grants at most one input per cycle and buffers granted flits in a small output FIFO, so downstream backpressure never combinationally reaches the inputs.

## Interface
- `WIDTH`, 11, flit width in bits.
- `NUM_IN`, 3, number of requesting inputs. Only 3 is supported; `NUM_IN` ≠ 3 is a compile-time error.
- `OUT_DEPTH`, 2, output FIFO depth in flits (≥1).
- `CNT_W`, 16, grant counter width. Used only with `RL_ARB_STATS_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  NUM_IN  per-input flit valid.
- `in_data`  in  NUM_IN×WIDTH  per-input flit; input i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  out  NUM_IN  one-hot grant; a flit transfers when `in_valid[i] && in_ready[i]`.
- `out_valid`  out  1  FIFO head valid.
- `out_data`  out  WIDTH  FIFO head flit.
- `out_ready`  in  1  downstream accept.
- `grant_cnt`  out  NUM_IN×CNT_W  per-input accepted-flit counters. Present only with `RL_ARB_STATS_EN`.

## Operation
- **Round-robin pointer `rr_ptr`** (2 bits) holds the last granted index.
  - The search order is `rr_ptr+1`, `rr_ptr+2`, `rr_ptr+3`, taken mod 3. Index 2 wraps to 0.
  - The first valid input in that order is granted.
- **Grant condition:** a grant is issued only when `count < OUT_DEPTH`.
  - A simultaneous pop does not free space for a push in the same cycle. There is no combinational path from `out_ready` to `in_ready`.
- **`in_ready`** is combinational from `in_valid`, `rr_ptr` and `count`. It is at most one-hot and is zero when no input is valid.
- **On a transfer:**
  - The flit is written at the FIFO tail.
  - `rr_ptr` takes the granted index.
  - `count` increments, unless a pop happens in the same cycle, in which case it is unchanged.
- **Pop:** occurs when `out_valid && out_ready`. The head pointer advances (wrapping at `OUT_DEPTH-1` to 0) and `count` decrements.
- **Input contract:** a sender must hold `in_valid` and `in_data` stable until its transfer completes. The arbiter neither checks nor modifies flit fields.
- **Idle:** with no valid input, `rr_ptr` holds its value.
- **Reset values** (asynchronous on `rst_n` low):
  - `out_valid` = 0, `out_data` = 0, `count` = 0.
  - Head and tail pointers = 0.
  - `rr_ptr` = 2, so the first grant goes to input 0.
  - `in_ready` = 0.
  - `grant_cnt` = 0.
- **Reset mid-operation:** all buffered flits are discarded. Flits held on the inputs are re-offered after reset and re-arbitrated from input 0.

## Timing
- **Latency:** a flit accepted at edge N is visible on `out_data`/`out_valid` after edge N. That is one cycle, when the FIFO was empty.
- **Throughput:** one flit per cycle, provided `out_ready` stays high and `OUT_DEPTH` ≥ 2.
  - With `OUT_DEPTH` = 1, the maximum rate is one flit every 2 cycles.
- **Full:** when `count == OUT_DEPTH`, `in_ready` = 0 for the whole cycle regardless of `out_ready`.
- **Empty:** `out_valid` = 0 and `out_data` holds its last value.
- **Fairness:** under continuous all-input contention with `out_ready` = 1, the grant sequence is 0, 1, 2, 0, … Each input waits at most 2 grants.

## Configuration
- **`RL_ARB_STATS_EN` defined:**
  - The `grant_cnt` port exists.
  - Counter i increments on every transfer from input i.
  - Counters saturate at 2^CNT_W−1 and are cleared by reset.
- **`RL_ARB_STATS_EN` undefined:** the port and the counters are absent. Arbitration behaviour is identical.

## Structure
- **Package `rl_noc_pkg`:**
  - `FLIT_W` = 11.
  - `typedef logic [FLIT_W-1:0] flit_t`.
  - Field constants: `TYPE_BIT` = 0, `DEST_LSB` = 1, `DEST_MSB` = 3, `PAYLOAD_LSB` = 4.
  - `NUM_PORTS` = 3.
- **Sub-module `rl_arb_fifo`:**
  - Parameterised by `WIDTH` and `OUT_DEPTH`.
  - Signals: push/pop, data, `count`, full/empty.
  - The arbiter top contains the round-robin logic, the grant logic and the optional counters.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream with 2 flits buffered → `out_valid` = 0 and `count` = 0 immediately. After release, with input 1 valid (0x2A3) → `in_ready` = 3'b010, and 0x2A3 appears on `out_data` one cycle later.
- **Single input:** input 0 streams 0x011, 0x013, 0x015 with `out_ready` = 1 → one flit out per cycle, in order, with one cycle of latency.
- **Contention:** all three inputs continuously valid (0x100, 0x200, 0x300), `out_ready` = 1 → grants 0, 1, 2, 0, 1, 2 and output in the same order. This covers `rr_ptr` wrap-around.
- **Backpressure:** `out_ready` = 0 with input 2 valid, `OUT_DEPTH` = 2 → two transfers, then `in_ready` = 0. Raise `out_ready` for 1 cycle → one pop, with no push in that cycle; push resumes the next cycle.
- **Stats** (with `RL_ARB_STATS_EN`, `CNT_W` = 4): 20 transfers from input 0 → `grant_cnt[0]` = 15 (saturated), others 0. Build without the macro → no `grant_cnt` port, and arbitration outputs are identical.
